// File: rtl/topk_result_reader_if.sv
// Result stream between the top-K reader and its consumer.
// The reader drives the beat fields and valid; the consumer drives ready.
interface topk_result_reader_if #(
    parameter int Index_Width = 16,
    parameter int Data_Width  = 8
);
    logic                   res_valid;
    logic                   res_ready;
    logic [Index_Width-1:0] res_index;
    logic [Data_Width-1:0]  res_data;
    logic [2:0]             res_rank;
    logic                   res_last;

    modport master (
        output res_valid, res_index, res_data, res_rank, res_last,
        input  res_ready
    );

    modport slave (
        input  res_valid, res_index, res_data, res_rank, res_last,
        output res_ready
    );
endinterface

// File: rtl/topk_result_reader.sv
// Top-K result reader: captures the final five sorter entries of a frame and
// streams them out one beat per handshake, rank 0 first.
// Optional build macro TOPK_SKIP_MIN_EN: entries equal to MIN are not
// emitted; without it every frame produces exactly five beats.
module topk_result_reader #(
    parameter int Data_Width  = 8,
    parameter int Index_Width = 16,
    parameter logic [Index_Width+Data_Width-1:0] MIN = 'h80
) (
    input  logic                              sys_clk,
    input  logic                              sys_rst_n,
    input  logic                              sorter_clr,
    input  logic [Index_Width+Data_Width-1:0] sorter_out0,
    input  logic [Index_Width+Data_Width-1:0] sorter_out1,
    input  logic [Index_Width+Data_Width-1:0] sorter_out2,
    input  logic [Index_Width+Data_Width-1:0] sorter_out3,
    input  logic [Index_Width+Data_Width-1:0] sorter_out4,
    input  logic                              sorter_valid,
    input  logic                              last_sort_o,
    topk_result_reader_if.master              res,
    output logic                              frame_done,
    output logic                              overflow
);
    localparam int EW = Index_Width + Data_Width;

    typedef enum logic {IDLE, SEND} state_e;

    state_e             state_q, state_d;
    logic [4:0][EW-1:0] buf_q, buf_d;
    logic [4:0]         mask_q, mask_d;
    logic [2:0]         ptr_q, ptr_d;
    logic               frame_done_q, frame_done_d;
    logic               overflow_q, overflow_d;

    logic [4:0][EW-1:0] entry_in;
    logic [4:0]         mask_in;
    logic               cap, hs, last_beat, accept;

    // Lowest set bit of the emit mask (first beat of a frame).
    function automatic logic [2:0] lo_bit(input logic [4:0] m);
        lo_bit = 3'd0;
        for (int i = 4; i >= 0; i--)
            if (m[i]) lo_bit = 3'(i);
    endfunction

    // Highest set bit of the emit mask (the beat flagged res_last).
    function automatic logic [2:0] hi_bit(input logic [4:0] m);
        hi_bit = 3'd0;
        for (int i = 0; i < 5; i++)
            if (m[i]) hi_bit = 3'(i);
    endfunction

    // Next set mask bit strictly above p.
    function automatic logic [2:0] next_bit(input logic [4:0] m, input logic [2:0] p);
        logic found;
        next_bit = p;
        found    = 1'b0;
        for (int i = 0; i < 5; i++)
            if (!found && i > int'(p) && m[i]) begin
                next_bit = 3'(i);
                found    = 1'b1;
            end
    endfunction

    assign entry_in = {sorter_out4, sorter_out3, sorter_out2, sorter_out1, sorter_out0};

    // Emit mask for a freshly captured frame.
    always_comb begin
`ifdef TOPK_SKIP_MIN_EN
        for (int i = 0; i < 5; i++) mask_in[i] = (entry_in[i] != MIN);
`else
        mask_in = 5'b11111;
`endif
    end

    assign cap       = sorter_valid && last_sort_o;
    assign hs        = (state_q == SEND) && res.res_ready;
    assign last_beat = (ptr_q == hi_bit(mask_q));

    // State and datapath registers; reset outranks clear, both outrank capture.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n || sorter_clr) begin
            state_q      <= IDLE;
            buf_q        <= '0;
            mask_q       <= '0;
            ptr_q        <= '0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            buf_q        <= buf_d;
            mask_q       <= mask_d;
            ptr_q        <= ptr_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
        end
    end

    // Next-state: capture, pointer advance, frame completion and overflow.
    always_comb begin
        state_d      = state_q;
        buf_d        = buf_q;
        mask_d       = mask_q;
        ptr_d        = ptr_q;
        frame_done_d = 1'b0;
        overflow_d   = overflow_q;
        accept       = 1'b0;
        case (state_q)
            IDLE: accept = cap;
            SEND: begin
                if (hs) begin
                    if (last_beat) begin
                        frame_done_d = 1'b1;
                        state_d      = IDLE;
                        // The final handshake frees the buffer, so a capture
                        // landing in the same cycle is taken, not dropped.
                        accept       = cap;
                    end else begin
                        ptr_d = next_bit(mask_q, ptr_q);
                    end
                end
                if (cap && !(hs && last_beat)) overflow_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (accept) begin
            buf_d  = entry_in;
            mask_d = mask_in;
            ptr_d  = lo_bit(mask_in);
            if (mask_in != 5'b00000) begin
                state_d = SEND;
            end else begin
                // Nothing to emit: the frame completes immediately.
                state_d      = IDLE;
                frame_done_d = 1'b1;
            end
        end
    end

    // Outputs: beat fields come from the buffer entry under the pointer,
    // forced to zero while no beat is offered.
    always_comb begin
        res.res_valid = (state_q == SEND);
        res.res_index = '0;
        res.res_data  = '0;
        res.res_rank  = '0;
        res.res_last  = 1'b0;
        if (state_q == SEND) begin
            res.res_index = buf_q[ptr_q][EW-1:Data_Width];
            res.res_data  = buf_q[ptr_q][Data_Width-1:0];
            res.res_rank  = ptr_q;
            res.res_last  = last_beat;
        end
        frame_done = frame_done_q;
        overflow   = overflow_q;
    end
endmodule
